// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the EX-stage ALU controller and its multiply/divide unit:
// ALU control codes, ALUOp encodings, funct encodings and the MDU FSM state type.
package alu_ctrl_pkg;

  // ALU control codes driven to the ALU
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_NONE = 4'b1111;

  // ALUOp from main control
  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_SLT   = 3'b011;

  // R-type funct field
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } mdu_state_e;

  // MULT/MULTU/DIV/DIVU share the 0110xx prefix; bit1 selects divide, bit0 unsigned
  function automatic logic is_mdu_arith(input logic [5:0] funct);
    return (funct[5:2] == 4'b0110);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath: one shift-add (multiply) or restoring
// subtract (divide) step per cycle on magnitudes, with sign fix-up applied to
// the result of the final step so HI/LO can be written on that same edge.
module mdu_iter
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              is_div_i,
  input  logic              is_signed_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              last_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);

  // acc_q: upper product half / partial remainder; sh_q: multiplier / dividend-quotient
  logic [DATA_W-1:0] acc_q, sh_q, opb_q;
  logic [CW-1:0]     cnt_q;
  logic              div_q, neg_res_q, neg_rem_q, bzero_q;

  logic              neg_a_s, neg_b_s;
  logic [DATA_W-1:0] abs_a_s, abs_b_s;
  logic [DATA_W:0]   sum_s, rem_sh_s;
  logic              ge_s;
  logic [DATA_W-1:0] acc_n_s, sh_n_s;
  logic [2*DATA_W-1:0] prod_s;

  // operand magnitudes and sign flags captured at load
  always_comb begin
    neg_a_s = is_signed_i & a_i[DATA_W-1];
    neg_b_s = is_signed_i & b_i[DATA_W-1];
    abs_a_s = neg_a_s ? (~a_i + {{(DATA_W-1){1'b0}}, 1'b1}) : a_i;
    abs_b_s = neg_b_s ? (~b_i + {{(DATA_W-1){1'b0}}, 1'b1}) : b_i;
  end

  // next iteration values and the sign-corrected result of this step
  always_comb begin
    sum_s    = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opb_q} : {(DATA_W+1){1'b0}});
    rem_sh_s = {acc_q, sh_q[DATA_W-1]};
    ge_s     = (rem_sh_s >= {1'b0, opb_q});
    if (div_q) begin
      acc_n_s = ge_s ? (rem_sh_s[DATA_W-1:0] - opb_q) : rem_sh_s[DATA_W-1:0];
      sh_n_s  = {sh_q[DATA_W-2:0], ge_s};
    end else begin
      acc_n_s = sum_s[DATA_W:1];
      sh_n_s  = {sum_s[0], sh_q[DATA_W-1:1]};
    end
    prod_s = neg_res_q ? (~{acc_n_s, sh_n_s} + {{(2*DATA_W-1){1'b0}}, 1'b1})
                       : {acc_n_s, sh_n_s};
    if (div_q) begin
      // divide by zero: quotient all ones, remainder already equals the dividend
      lo_o = bzero_q ? {DATA_W{1'b1}}
                     : (neg_res_q ? (~sh_n_s + {{(DATA_W-1){1'b0}}, 1'b1}) : sh_n_s);
      hi_o = neg_rem_q ? (~acc_n_s + {{(DATA_W-1){1'b0}}, 1'b1}) : acc_n_s;
    end else begin
      hi_o = prod_s[2*DATA_W-1:DATA_W];
      lo_o = prod_s[DATA_W-1:0];
    end
  end

  assign last_o = (cnt_q == CNT_LAST);

  // datapath registers: load on start, advance one step per busy cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q     <= {DATA_W{1'b0}};
      sh_q      <= {DATA_W{1'b0}};
      opb_q     <= {DATA_W{1'b0}};
      cnt_q     <= {CW{1'b0}};
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
    end else if (load_i) begin
      acc_q     <= {DATA_W{1'b0}};
      sh_q      <= abs_a_s;
      opb_q     <= abs_b_s;
      cnt_q     <= {CW{1'b0}};
      div_q     <= is_div_i;
      neg_res_q <= neg_a_s ^ neg_b_s;
      neg_rem_q <= neg_a_s;
      bzero_q   <= (b_i == {DATA_W{1'b0}});
    end else if (step_i) begin
      acc_q <= acc_n_s;
      sh_q  <= sh_n_s;
      cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/alu_ctrl_mdu.sv
// EX-stage ALU controller with iterative multiply/divide unit and HI/LO registers.
// Decodes ALUOp/funct to the ALU control code, sequences MULT[U]/DIV[U] through
// IDLE/BUSY/DONE while stalling the pipeline, and serves MFHI/MFLO/MTHI/MTLO.
// Build option: MDU_ZERO_SKIP_EN -- multiplies with a zero operand and divides by
// zero finish in the start cycle instead of iterating.
module alu_ctrl_mdu
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              kill_i,
  input  logic [2:0]        alu_op_i,
  input  logic [5:0]        funct_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  output logic [3:0]        alu_ctrl_o,
  output logic              hilo_sel_o,
  output logic [DATA_W-1:0] hilo_data_o,
  output logic              stall_o
);

  mdu_state_e        state_q, state_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic              rtype_s, start_s, skip_s, mt_we_s, load_s, step_s, last_s;
  logic [DATA_W-1:0] res_hi_s, res_lo_s, zs_hi_s, zs_lo_s;

  // ALU control decode
  always_comb begin
    alu_ctrl_o = ALU_NONE;
    case (alu_op_i)
      ALUOP_ADD: alu_ctrl_o = ALU_ADD;
      ALUOP_SUB: alu_ctrl_o = ALU_SUB;
      ALUOP_SLT: alu_ctrl_o = ALU_SLT;
      ALUOP_RTYPE: begin
        case (funct_i)
          FN_ADD, FN_ADDU: alu_ctrl_o = ALU_ADD;
          FN_SUB, FN_SUBU: alu_ctrl_o = ALU_SUB;
          FN_AND:          alu_ctrl_o = ALU_AND;
          FN_OR:           alu_ctrl_o = ALU_OR;
          FN_XOR:          alu_ctrl_o = ALU_XOR;
          FN_NOR:          alu_ctrl_o = ALU_NOR;
          FN_SLT:          alu_ctrl_o = ALU_SLT;
          FN_SLTU:         alu_ctrl_o = ALU_SLTU;
          default:         alu_ctrl_o = ALU_NONE;
        endcase
      end
      default: alu_ctrl_o = ALU_NONE;
    endcase
  end

  assign rtype_s = (alu_op_i == ALUOP_RTYPE);
  assign start_s = ~rst_i & valid_i & ~kill_i & (state_q == ST_IDLE)
                 & rtype_s & is_mdu_arith(funct_i);
  assign stall_o = start_s | (state_q == ST_BUSY);
  assign mt_we_s = valid_i & ~kill_i & ~stall_o & rtype_s
                 & ((funct_i == FN_MTHI) | (funct_i == FN_MTLO));

  // zero-operand shortcut results: multiply gives 0, divide-by-zero gives HI=A, LO=ones
  assign zs_hi_s = funct_i[1] ? rs_data_i : {DATA_W{1'b0}};
  assign zs_lo_s = funct_i[1] ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
`ifdef MDU_ZERO_SKIP_EN
  assign skip_s = funct_i[1] ? (rt_data_i == {DATA_W{1'b0}})
                             : ((rs_data_i == {DATA_W{1'b0}}) | (rt_data_i == {DATA_W{1'b0}}));
`else
  assign skip_s = 1'b0;
`endif

  // MFHI/MFLO result mux
  always_comb begin
    hilo_sel_o  = 1'b0;
    hilo_data_o = {DATA_W{1'b0}};
    if (rtype_s) begin
      case (funct_i)
        FN_MFHI: begin hilo_sel_o = 1'b1; hilo_data_o = hi_q; end
        FN_MFLO: begin hilo_sel_o = 1'b1; hilo_data_o = lo_q; end
        default: begin hilo_sel_o = 1'b0; hilo_data_o = {DATA_W{1'b0}}; end
      endcase
    end else begin
      hilo_sel_o  = 1'b0;
      hilo_data_o = {DATA_W{1'b0}};
    end
  end

  // FSM next state, HI/LO updates and datapath control
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    load_s  = start_s;
    step_s  = 1'b0;
    if (mt_we_s) begin
      if (funct_i == FN_MTHI) hi_d = rs_data_i;
      else                    lo_d = rs_data_i;
    end else begin
      hi_d = hi_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (start_s && skip_s) begin
          hi_d    = zs_hi_s;
          lo_d    = zs_lo_s;
          state_d = ST_DONE;
        end else if (start_s) begin
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (kill_i) begin
          state_d = ST_IDLE;
        end else if (last_s) begin
          step_s  = 1'b1;
          hi_d    = res_hi_s;
          lo_d    = res_lo_s;
          state_d = ST_DONE;
        end else begin
          step_s  = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // state and HI/LO registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      hi_q    <= {DATA_W{1'b0}};
      lo_q    <= {DATA_W{1'b0}};
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  mdu_iter #(.DATA_W(DATA_W)) u_mdu_iter (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (load_s),
    .step_i      (step_s),
    .is_div_i    (funct_i[1]),
    .is_signed_i (~funct_i[0]),
    .a_i         (rs_data_i),
    .b_i         (rt_data_i),
    .last_o      (last_s),
    .hi_o        (res_hi_s),
    .lo_o        (res_lo_s)
  );

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Self-checking bench for alu_ctrl_mdu (DATA_W=32). Expected values are queued
// when stimulus is issued and popped when the DUT result is observed.
module tb_alu_ctrl_mdu;

  localparam int W = 32;
  localparam logic [2:0] OP_ADD = 3'b000, OP_R = 3'b010;
  localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001, F_DIV = 6'b011010,
                         F_DIVU = 6'b011011, F_MFHI = 6'b010000, F_MTHI = 6'b010001,
                         F_MFLO = 6'b010010, F_MTLO = 6'b010011;
`ifdef MDU_ZERO_SKIP_EN
  localparam int ZSTALL = 1;
`else
  localparam int ZSTALL = 33;
`endif

  logic         clk = 1'b0;
  logic         rst_i, valid_i, kill_i;
  logic [2:0]   alu_op_i;
  logic [5:0]   funct_i;
  logic [W-1:0] rs_data_i, rt_data_i;
  logic [3:0]   alu_ctrl_o;
  logic         hilo_sel_o;
  logic [W-1:0] hilo_data_o;
  logic         stall_o;

  always #5 clk = ~clk;

  alu_ctrl_mdu #(.DATA_W(W)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .kill_i(kill_i),
    .alu_op_i(alu_op_i), .funct_i(funct_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i),
    .alu_ctrl_o(alu_ctrl_o), .hilo_sel_o(hilo_sel_o), .hilo_data_o(hilo_data_o),
    .stall_o(stall_o)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  task automatic push(input string t, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(t);
  endtask

  task automatic issue(input logic [2:0] op, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic v, input logic k);
    @(posedge clk); #1;
    alu_op_i = op; funct_i = f; rs_data_i = a; rt_data_i = b; valid_i = v; kill_i = k;
  endtask

  // issue an MDU op and count stall cycles (bounded); operands scrambled after start
  task automatic run_mdu(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         output int stalls);
    issue(OP_R, f, a, b, 1'b1, 1'b0);
    stalls = 0;
    @(negedge clk);
    while (stall_o === 1'b1 && stalls < 200) begin
      stalls++;
      @(posedge clk); #1;
      rs_data_i = $urandom;
      rt_data_i = $urandom;
      @(negedge clk);
    end
  endtask

  task automatic read_hilo(input logic hi, output logic [31:0] d, output logic s);
    issue(OP_R, hi ? F_MFHI : F_MFLO, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    d = hilo_data_o;
    s = hilo_sel_o;
  endtask

  task automatic test_reset();
    logic [31:0] obs [5];
    logic        s;
    rst_i = 1'b1; valid_i = 1'b1; kill_i = 1'b0; alu_op_i = OP_R; funct_i = F_MFLO;
    rs_data_i = 32'h0; rt_data_i = 32'h0;
    push("rst_stall", 32'd0); push("rst_sel", 32'd1); push("rst_data", 32'd0);
    push("rst_hi", 32'd0); push("rst_lo", 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    obs[0] = {31'd0, stall_o}; obs[1] = {31'd0, hilo_sel_o}; obs[2] = hilo_data_o;
    @(posedge clk); #1; rst_i = 1'b0;
    read_hilo(1'b1, obs[3], s);
    read_hilo(1'b0, obs[4], s);
    for (int i = 0; i < 5; i++) begin
      logic [31:0] e; string t;
      e = exp_q.pop_front(); t = tag_q.pop_front(); n_cmp++;
      if (obs[i] !== e) begin n_err++; $display("FAIL %s: got %h expected %h", t, obs[i], e); end
    end
  endtask

  task automatic test_decode();
    logic [5:0] fl [20];
    logic [3:0] rc [20];
    fl = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101, 6'b100110,
           6'b100111, 6'b101010, 6'b101011, F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI,
           F_MFLO, F_MTHI, F_MTLO, 6'b000000, 6'b111111};
    rc = '{4'h2, 4'h2, 4'h6, 4'h6, 4'h0, 4'h1, 4'h3, 4'hC, 4'h7, 4'h8,
           4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    for (int op = 0; op < 8; op++) begin
      for (int j = 0; j < 20; j++) begin
        logic [3:0] ec; logic es; logic [31:0] obs, e; string t;
        case (op)
          0:       ec = 4'h2;
          1:       ec = 4'h6;
          2:       ec = rc[j];
          3:       ec = 4'h7;
          default: ec = 4'hF;
        endcase
        es = (op == 2) && (fl[j] == F_MFHI || fl[j] == F_MFLO);
        push($sformatf("decode op%0d f%b", op, fl[j]), {27'd0, es, ec});
        issue(3'(op), fl[j], 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        obs = {27'd0, hilo_sel_o, alu_ctrl_o};
        e = exp_q.pop_front(); t = tag_q.pop_front(); n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL %s: got %h expected %h", t, obs, e); end
      end
    end
  endtask

  task automatic test_hilo();
    logic [31:0] obs [10];
    logic        s;
    issue(OP_R, F_MTHI, 32'h0000_1234, 32'h0, 1'b1, 1'b0);
    push("mfhi_sel", 32'd1); push("mfhi_data", 32'h0000_1234);
    read_hilo(1'b1, obs[1], s); obs[0] = {31'd0, s};
    issue(OP_R, F_MTLO, 32'h0000_CAFE, 32'h0, 1'b1, 1'b0);
    push("mflo_sel", 32'd1); push("mflo_data", 32'h0000_CAFE);
    read_hilo(1'b0, obs[3], s); obs[2] = {31'd0, s};
    issue(OP_R, F_MTHI, 32'h0000_DEAD, 32'h0, 1'b1, 1'b1);
    push("mthi_killed", 32'h0000_1234);
    read_hilo(1'b1, obs[4], s);
    issue(OP_R, F_MTLO, 32'h0000_BEEF, 32'h0, 1'b0, 1'b0);
    push("mtlo_invalid", 32'h0000_CAFE);
    read_hilo(1'b0, obs[5], s);
    issue(OP_ADD, F_MFHI, 32'h0, 32'h0, 1'b1, 1'b0);
    push("nonr_sel", 32'd0); push("nonr_data", 32'd0);
    @(negedge clk);
    obs[6] = {31'd0, hilo_sel_o}; obs[7] = hilo_data_o;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] e; string t;
      e = exp_q.pop_front(); t = tag_q.pop_front(); n_cmp++;
      if (obs[i] !== e) begin n_err++; $display("FAIL %s: got %h expected %h", t, obs[i], e); end
    end
  endtask

  task automatic test_mult();
    logic [5:0]  fn [4];
    logic [31:0] a [4], b [4], eh [4], el [4];
    fn = '{F_MULT, F_MULTU, F_MULT, F_MULT};
    a  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0007};
    b  = '{32'h0000_0005, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFA};
    eh = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h4000_0000, 32'hFFFF_FFFF};
    el = '{32'hFFFF_FFF1, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFD6};
    for (int i = 0; i < 4; i++) begin
      logic [31:0] obs [3]; int st; logic s;
      push($sformatf("mult%0d_stall", i), 32'd33);
      push($sformatf("mult%0d_hi", i), eh[i]);
      push($sformatf("mult%0d_lo", i), el[i]);
      run_mdu(fn[i], a[i], b[i], st);
      obs[0] = 32'(st);
      read_hilo(1'b1, obs[1], s);
      read_hilo(1'b0, obs[2], s);
      for (int k = 0; k < 3; k++) begin
        logic [31:0] e; string t;
        e = exp_q.pop_front(); t = tag_q.pop_front(); n_cmp++;
        if (obs[k] !== e) begin n_err++; $display("FAIL %s: got %h expected %h", t, obs[k], e); end
      end
    end
  endtask

  task automatic test_div();
    logic [5:0]  fn [6];
    logic [31:0] a [6], b [6], eh [6], el [6];
    fn = '{F_DIV, F_DIVU, F_DIV, F_DIVU, F_DIV, F_DIV};
    a  = '{32'hFFFF_FFF9, 32'h0000_0007, 32'h8000_0000, 32'd100, 32'h0000_0007, 32'hFFFF_FFF9};
    b  = '{32'h0000_0002, 32'h0000_0000, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFE, 32'h0000_0000};
    eh = '{32'hFFFF_FFFF, 32'h0000_0007, 32'h0000_0000, 32'd2, 32'h0000_0001, 32'hFFFF_FFF9};
    el = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    for (int i = 0; i < 6; i++) begin
      logic [31:0] obs [3]; int st; logic s;
      push($sformatf("div%0d_stall", i), (b[i] == 32'h0) ? 32'(ZSTALL) : 32'd33);
      push($sformatf("div%0d_hi", i), eh[i]);
      push($sformatf("div%0d_lo", i), el[i]);
      run_mdu(fn[i], a[i], b[i], st);
      obs[0] = 32'(st);
      read_hilo(1'b1, obs[1], s);
      read_hilo(1'b0, obs[2], s);
      for (int k = 0; k < 3; k++) begin
        logic [31:0] e; string t;
        e = exp_q.pop_front(); t = tag_q.pop_front(); n_cmp++;
        if (obs[k] !== e) begin n_err++; $display("FAIL %s: got %h expected %h", t, obs[k], e); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] obs [4]; int st; logic s;
    push("b2b_stall1", 32'd33); push("b2b_stall2", 32'd33);
    push("b2b_hi", 32'd2); push("b2b_lo", 32'd14);
    run_mdu(F_MULT, 32'd6, 32'd7, st);  obs[0] = 32'(st);
    run_mdu(F_DIVU, 32'd100, 32'd7, st); obs[1] = 32'(st);
    read_hilo(1'b1, obs[2], s);
    read_hilo(1'b0, obs[3], s);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] e; string t;
      e = exp_q.pop_front(); t = tag_q.pop_front(); n_cmp++;
      if (obs[k] !== e) begin n_err++; $display("FAIL %s: got %h expected %h", t, obs[k], e); end
    end
  endtask

  task automatic test_kill();
    logic [31:0] obs [7]; int st; logic s;
    issue(OP_R, F_MTHI, 32'hA5A5_0001, 32'h0, 1'b1, 1'b0);
    issue(OP_R, F_MTLO, 32'h5A5A_0002, 32'h0, 1'b1, 1'b0);
    push("kill_cycle_stall", 32'd1); push("kill_next_stall", 32'd0);
    push("kill_hi", 32'hA5A5_0001); push("kill_lo", 32'h5A5A_0002);
    push("restart_stall", 32'd33); push("restart_hi", 32'd0); push("restart_lo", 32'd42);
    issue(OP_R, F_MULTU, 32'h1234_5678, 32'h0000_0009, 1'b1, 1'b0);
    @(negedge clk);
    repeat (9) @(negedge clk);
    issue(OP_R, F_MULTU, 32'h1234_5678, 32'h0000_0009, 1'b1, 1'b1);
    @(negedge clk); obs[0] = {31'd0, stall_o};
    issue(OP_ADD, 6'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk); obs[1] = {31'd0, stall_o};
    read_hilo(1'b1, obs[2], s);
    read_hilo(1'b0, obs[3], s);
    run_mdu(F_MULT, 32'd6, 32'd7, st); obs[4] = 32'(st);
    read_hilo(1'b1, obs[5], s);
    read_hilo(1'b0, obs[6], s);
    for (int k = 0; k < 7; k++) begin
      logic [31:0] e; string t;
      e = exp_q.pop_front(); t = tag_q.pop_front(); n_cmp++;
      if (obs[k] !== e) begin n_err++; $display("FAIL %s: got %h expected %h", t, obs[k], e); end
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [31:0] obs [3]; logic s;
    issue(OP_R, F_MTHI, 32'h0000_0077, 32'h0, 1'b1, 1'b0);
    issue(OP_R, F_MTLO, 32'h0000_0088, 32'h0, 1'b1, 1'b0);
    issue(OP_R, F_MULT, 32'd3, 32'd3, 1'b1, 1'b0);
    push("rstbusy_stall", 32'd0); push("rstbusy_hi", 32'd0); push("rstbusy_lo", 32'd0);
    repeat (6) @(negedge clk);
    issue(OP_ADD, 6'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst_i = 1'b1;
    @(posedge clk); #1; rst_i = 1'b0;
    @(negedge clk); obs[0] = {31'd0, stall_o};
    read_hilo(1'b1, obs[1], s);
    read_hilo(1'b0, obs[2], s);
    for (int k = 0; k < 3; k++) begin
      logic [31:0] e; string t;
      e = exp_q.pop_front(); t = tag_q.pop_front(); n_cmp++;
      if (obs[k] !== e) begin n_err++; $display("FAIL %s: got %h expected %h", t, obs[k], e); end
    end
  endtask

  task automatic test_zero_skip();
    logic [31:0] obs [6]; int st; logic s;
    issue(OP_R, F_MTHI, 32'h0000_0011, 32'h0, 1'b1, 1'b0);
    issue(OP_R, F_MTLO, 32'h0000_0022, 32'h0, 1'b1, 1'b0);
    push("zmul_stall", 32'(ZSTALL)); push("zmul_hi", 32'd0); push("zmul_lo", 32'd0);
    run_mdu(F_MULT, 32'd0, 32'd9, st); obs[0] = 32'(st);
    read_hilo(1'b1, obs[1], s);
    read_hilo(1'b0, obs[2], s);
    issue(OP_R, F_MTHI, 32'h0000_0033, 32'h0, 1'b1, 1'b0);
    issue(OP_R, F_MTLO, 32'h0000_0044, 32'h0, 1'b1, 1'b0);
    push("zmulu_stall", 32'(ZSTALL)); push("zmulu_hi", 32'd0); push("zmulu_lo", 32'd0);
    run_mdu(F_MULTU, 32'd5, 32'd0, st); obs[3] = 32'(st);
    read_hilo(1'b1, obs[4], s);
    read_hilo(1'b0, obs[5], s);
    for (int k = 0; k < 6; k++) begin
      logic [31:0] e; string t;
      e = exp_q.pop_front(); t = tag_q.pop_front(); n_cmp++;
      if (obs[k] !== e) begin n_err++; $display("FAIL %s: got %h expected %h", t, obs[k], e); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_decode();
    test_hilo();
    test_mult();
    test_div();
    test_back_to_back();
    test_kill();
    test_reset_mid_busy();
    test_zero_skip();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
